rank_argmax: RTL and testbench

Streaming, parametrised argmax unit for the PageRank datapath: it accepts a frame of rank values one per cycle over a valid/ready handshake and reports the maximum value, its position, and the element count when the frame ends. It generalises the team's fixed 32-bit magnitude comparator to any width, adds state across a stream, and optionally compares two's-complement values. It sits after the rank-update stage and feeds top-page selection and convergence logic.

---
 rtl/rank_argmax.sv | 101 ++++++++++
 tb/tb_rank_argmax.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rank_argmax.sv
// Streaming argmax over a frame of rank values: reports max, first index of max, count, overflow.
// Latency: result visible the cycle after the in_last handshake; one element per cycle while accepting.
// Backpressure: in_ready drops while a result waits on out_ready. Define RANK_ARGMAX_SIGNED_EN for signed compare.
module rank_argmax #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W-1:0] out_cnt,
  output logic             out_ovf
);

  typedef enum logic [1:0] {FIRST, ACC, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             gt;
  logic [WIDTH-1:0] max_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] pos_q;
  logic             ovf_q;

  assign accept = in_valid && in_ready;

  // Strict greater-than keeps the earliest index on ties.
  always_comb begin
`ifdef RANK_ARGMAX_SIGNED_EN
    gt = $signed(in_data) > $signed(max_q);
`else
    gt = in_data > max_q;
`endif
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FIRST;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode; both handshakes come straight from the state flop.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FIRST: begin
        in_ready = 1'b1;
        if (accept) state_nxt = in_last ? DONE : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (accept && in_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = FIRST;
      end
      default: state_nxt = FIRST;
    endcase
  end

  // Running max/index/position; these hold still in DONE because nothing is accepted there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      idx_q <= '0;
      pos_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      if (state == FIRST) begin
        max_q <= in_data;
        idx_q <= '0;
        pos_q <= IDX_W'(1);
        ovf_q <= 1'b0;
      end else begin
        if (gt) begin
          max_q <= in_data;
          idx_q <= pos_q;
        end
        pos_q <= pos_q + IDX_W'(1);
        // Position counter wrapping means count and index no longer fit.
        if (&pos_q) ovf_q <= 1'b1;
      end
    end
  end

  assign out_max = max_q;
  assign out_idx = idx_q;
  assign out_cnt = pos_q;
  assign out_ovf = ovf_q;

endmodule

// File: tb/tb_rank_argmax.sv
module tb_rank_argmax;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_max;
  logic [15:0] out_idx, out_cnt;

  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [31:0] s_out_max;
  logic [2:0]  s_out_idx, s_out_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rank_argmax #(.WIDTH(32), .IDX_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_idx(out_idx), .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  rank_argmax #(.WIDTH(32), .IDX_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_max(s_out_max), .out_idx(s_out_idx), .out_cnt(s_out_cnt), .out_ovf(s_out_ovf)
  );

  // Reference compare: the frame's ordering rule.
  function automatic bit ref_gt(input logic [31:0] a, input logic [31:0] b);
`ifdef RANK_ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Reference result for a whole frame held in a queue, for an index width iw.
  function automatic void ref_frame(input logic [31:0] q[$], input int iw,
                                    output logic [31:0] m, output int idx,
                                    output int cnt, output bit ovf);
    int best;
    best = 0;
    m = q[0];
    for (int i = 1; i < q.size(); i++)
      if (ref_gt(q[i], m)) begin
        m = q[i];
        best = i;
      end
    idx = best % (1 << iw);
    cnt = q.size() % (1 << iw);
    ovf = q.size() > ((1 << iw) - 1);
  endfunction

  // Called at a negedge; returns at the negedge after the element is accepted.
  task automatic push(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_max, out_idx, out_cnt, out_ovf} !== {1'b1, 1'b0, 32'd0, 16'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b max=%h idx=%h cnt=%h ovf=%b, required rdy=1 vld=0 all zero",
               in_ready, out_valid, out_max, out_idx, out_cnt, out_ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(32'd5, 1'b0);
    push(32'd9, 1'b0);
    push(32'd3, 1'b0);
    push(32'd9, 1'b1);
    checks++;
    if ({out_valid, in_ready, out_max, out_idx, out_cnt, out_ovf} !== {1'b1, 1'b0, 32'd9, 16'd1, 16'd4, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: vld=%b rdy=%b max=%h idx=%0d cnt=%0d ovf=%b, required 1 0 9 1 4 0",
               out_valid, in_ready, out_max, out_idx, out_cnt, out_ovf);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_one_cycle: vld=%b rdy=%b, required vld=0 rdy=1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_sign();
    logic [31:0] em;
    logic [15:0] ei;
`ifdef RANK_ARGMAX_SIGNED_EN
    em = 32'd1;        ei = 16'd1;
`else
    em = 32'h8000_0000; ei = 16'd0;
`endif
    out_ready = 1'b1;
    push(32'h8000_0000, 1'b0);
    push(32'h0000_0001, 1'b1);
    checks++;
    if ({out_valid, out_max, out_idx, out_cnt} !== {1'b1, em, ei, 16'd2}) begin
      errors++;
      $display("FAIL sign_compare: vld=%b max=%h idx=%0d cnt=%0d, required 1 %h %0d 2",
               out_valid, out_max, out_idx, out_cnt, em, ei);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    push(32'd7, 1'b1);
    checks++;
    if ({out_valid, in_ready, out_max, out_idx, out_cnt, out_ovf} !== {1'b1, 1'b0, 32'd7, 16'd0, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_elem: vld=%b rdy=%b max=%h idx=%0d cnt=%0d ovf=%b, required 1 0 7 0 1 0",
               out_valid, in_ready, out_max, out_idx, out_cnt, out_ovf);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(32'd11, 1'b0);
    push(32'd4, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({out_valid, in_ready, out_max, out_idx, out_cnt, out_ovf} !== {1'b1, 1'b0, 32'd11, 16'd0, 16'd2, 1'b0}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: vld=%b rdy=%b max=%h idx=%0d cnt=%0d ovf=%b, required 1 0 b 0 2 0",
                 c, out_valid, in_ready, out_max, out_idx, out_cnt, out_ovf);
      end
      // Stray element offered while blocked; it must not be taken.
      in_valid = 1'b1; in_data = 32'd99; in_last = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release: vld=%b rdy=%b, required vld=0 rdy=1", out_valid, in_ready);
    end
    push(32'd2, 1'b1);
    checks++;
    if ({out_valid, out_max, out_idx, out_cnt} !== {1'b1, 32'd2, 16'd0, 16'd1}) begin
      errors++;
      $display("FAIL backpressure_next: vld=%b max=%h idx=%0d cnt=%0d, required 1 2 0 1",
               out_valid, out_max, out_idx, out_cnt);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) push(32'(i), (i == 8));
    checks++;
    if ({s_out_valid, s_out_max, s_out_idx, s_out_cnt, s_out_ovf} !== {1'b1, 32'd8, 3'd0, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL overflow_small: vld=%b max=%h idx=%0d cnt=%0d ovf=%b, required 1 8 0 1 1",
               s_out_valid, s_out_max, s_out_idx, s_out_cnt, s_out_ovf);
    end
    checks++;
    if ({out_max, out_idx, out_cnt, out_ovf} !== {32'd8, 16'd8, 16'd9, 1'b0}) begin
      errors++;
      $display("FAIL overflow_wide: max=%h idx=%0d cnt=%0d ovf=%b, required 8 8 9 0",
               out_max, out_idx, out_cnt, out_ovf);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_midframe_reset();
    out_ready = 1'b1;
    push(32'd4, 1'b0);
    push(32'd6, 1'b0);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_max, out_cnt} !== {1'b0, 1'b1, 32'd0, 16'd0}) begin
        errors++;
        $display("FAIL midreset_hold[%0d]: vld=%b rdy=%b max=%h cnt=%0d, required 0 1 0 0",
                 c, out_valid, in_ready, out_max, out_cnt);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    push(32'd3, 1'b1);
    checks++;
    if ({out_valid, out_max, out_idx, out_cnt, out_ovf} !== {1'b1, 32'd3, 16'd0, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL midreset_next: vld=%b max=%h idx=%0d cnt=%0d ovf=%b, required 1 3 0 1 0",
               out_valid, out_max, out_idx, out_cnt, out_ovf);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      logic [31:0] q[$];
      int          len;
      logic [31:0] em, sm;
      int          ei, ec, si, sc;
      bit          eo, so, done;
      logic [31:0] v;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        v = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
        q.push_back(v);
      end
      ref_frame(q, 16, em, ei, ec, eo);
      ref_frame(q, 3, sm, si, sc, so);
      out_ready = 1'b0;
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        push(q[i], (i == len - 1));
      end
      done = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
        out_ready = (n >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        if (out_ready) begin
          done = 1'b1;
          checks++;
          if ({out_valid, out_max, out_idx, out_cnt, out_ovf} !== {1'b1, em, 16'(ei), 16'(ec), eo}) begin
            errors++;
            $display("FAIL random_wide[%0d]: vld=%b max=%h idx=%0d cnt=%0d ovf=%b, required 1 %h %0d %0d %b",
                     f, out_valid, out_max, out_idx, out_cnt, out_ovf, em, ei, ec, eo);
          end
          checks++;
          if ({s_out_valid, s_out_max, s_out_idx, s_out_cnt, s_out_ovf} !== {1'b1, sm, 3'(si), 3'(sc), so}) begin
            errors++;
            $display("FAIL random_small[%0d]: vld=%b max=%h idx=%0d cnt=%0d ovf=%b, required 1 %h %0d %0d %b",
                     f, s_out_valid, s_out_max, s_out_idx, s_out_cnt, s_out_ovf, sm, si, sc, so);
          end
        end
        @(negedge clk);
      end
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_single();
    test_backpressure();
    test_overflow();
    test_midframe_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
